// File: rtl/ram_arb_pkg.sv
// Shared types and sizing constants for the RAM port arbiter and its picker.
package ram_arb_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int MAX_LOCK_DEF = 8;
    localparam int PTR_W        = $clog2(N_REQ_DEF);
    localparam int CNT_W        = $clog2(MAX_LOCK_DEF + 1);
    localparam int BE_W         = 4;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded burst locking sharing one RAM port between N_REQ requesters.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ-1:0]         we,
    input  logic [N_REQ*ADDR_W-1:0]  addr,
    input  logic [N_REQ*DATA_W-1:0]  wdata,
    input  logic [N_REQ*BE_W-1:0]    be,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        ram_address,
    output logic [DATA_W-1:0]        ram_data_in,
    output logic [BE_W-1:0]          ram_byte_enablers,
    output logic                     ram_write_enable,
    input  logic [DATA_W-1:0]        ram_data_out
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rvld_q, rvld_d;
    logic [N_REQ-1:0]  rtag_q, rtag_d;

    logic [N_REQ-1:0]  pk_gnt;
    logic [PW-1:0]     pk_idx;
    logic              pk_any;
    logic              own_hold;
    logic [N_REQ-1:0]  sel_gnt;
    logic [PW-1:0]     sel_idx;
    logic              sel_any;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    rr_priority_picker #(
        .N  (N_REQ),
        .PW (PW)
    ) u_picker (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pk_gnt),
        .idx_o (pk_idx),
        .any_o (pk_any)
    );

    // The lock owner bypasses the picker while it keeps requesting.
    always_comb begin
        own_hold = (state_q == LOCKED) && req[owner_q];
        sel_gnt  = pk_gnt;
        sel_idx  = pk_idx;
        sel_any  = pk_any;
        if (own_hold) begin
            sel_gnt          = '0;
            sel_gnt[owner_q] = 1'b1;
            sel_idx          = owner_q;
            sel_any          = 1'b1;
        end
        if (!reset) begin
            sel_gnt = '0;
            sel_any = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rvld_d  = 1'b0;
        rtag_d  = '0;
        if (state_q == LOCKED && !req[owner_q]) begin
            state_d = ARB;
            cnt_d   = '0;
            ptr_d   = ptr_inc(owner_q);
        end
        if (sel_any) begin
            if (!we[sel_idx]) begin
                rvld_d = 1'b1;
                rtag_d = sel_gnt;
            end
            if (own_hold) begin
                if (!lock[owner_q] || (int'(cnt_q) + 1 >= MAX_LOCK)) begin
                    state_d = ARB;
                    cnt_d   = '0;
                    ptr_d   = ptr_inc(owner_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                ptr_d = ptr_inc(sel_idx);
                if (lock[sel_idx] && (MAX_LOCK > 1)) begin
                    state_d = LOCKED;
                    owner_d = sel_idx;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = ARB;
                    cnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rvld_q  <= 1'b0;
            rtag_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rvld_q  <= rvld_d;
            rtag_q  <= rtag_d;
        end
    end

    always_comb begin
        gnt               = sel_gnt;
        ram_address       = '0;
        ram_data_in       = '0;
        ram_byte_enablers = '0;
        ram_write_enable  = 1'b0;
        if (sel_any) begin
            ram_address       = addr[int'(sel_idx)*ADDR_W +: ADDR_W];
            ram_data_in       = wdata[int'(sel_idx)*DATA_W +: DATA_W];
            ram_byte_enablers = be[int'(sel_idx)*BE_W +: BE_W];
            ram_write_enable  = we[sel_idx];
        end
        rvalid = rvld_q ? rtag_q : '0;
        rdata  = ram_data_out;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and random bench for ram_port_arbiter with a word RAM and a reference arbitration model.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam int ML = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N*4-1:0]  be;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, ram_data_in, ram_data_out;
    logic [AW-1:0]   ram_address;
    logic [3:0]      ram_byte_enablers;
    logic            ram_write_enable;

    ram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clock(clock), .reset(reset), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .be(be), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_byte_enablers(ram_byte_enablers), .ram_write_enable(ram_write_enable),
        .ram_data_out(ram_data_out)
    );

    function automatic logic [31:0] init_word(int a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // Behavioural RAM: synchronous 1-cycle read, byte-enabled write.
    logic [31:0] mem  [0:65535];
    bit          memv [0:65535];
    int          ra;
    logic [31:0] rw;
    always @(posedge clock) begin
        ra = int'(ram_address[AW-1:2]);
        rw = memv[ra] ? mem[ra] : init_word(ra);
        if (ram_write_enable) begin
            for (int b = 0; b < 4; b++)
                if (ram_byte_enablers[b]) rw[b*8 +: 8] = ram_data_in[b*8 +: 8];
            mem[ra]  <= rw;
            memv[ra] <= 1'b1;
        end
        ram_data_out <= memv[ra] ? mem[ra] : init_word(ra);
    end

    // Reference model state
    int          m_ptr, m_cnt, m_owner, eg, last_g;
    bit          m_lock, pv;
    int          pidx;
    logic [31:0] pdata;
    logic [31:0] sh  [0:65535];
    bit          shv [0:65535];
    int          chks, errs;

    function automatic logic [31:0] sh_rd(int a);
        return shv[a] ? sh[a] : init_word(a);
    endfunction

    function automatic int pick();
        if (!reset) return -1;
        if (m_lock && req[m_owner]) return m_owner;
        for (int k = 0; k < N; k++)
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] g);
        #1;
        check(tag, 64'(gnt), 64'(g));
    endtask

    // One clock: check combinational outputs and read return, then advance the model.
    task automatic cyc();
        logic [63:0] ex;
        logic [31:0] w;
        int a;
        #1;
        if (!reset) begin
            m_ptr = 0; m_lock = 0; m_cnt = 0; pv = 0;
        end
        eg = pick();
        ex = (eg >= 0) ? (64'(1) << eg) : 64'(0);
        check("gnt", 64'(gnt), ex);
        if (eg >= 0) begin
            check("ram_we", 64'(ram_write_enable), 64'(we[eg]));
            check("ram_be", 64'(ram_byte_enablers), 64'(be[eg*4 +: 4]));
            check("ram_addr", 64'(ram_address), 64'(addr[eg*AW +: AW]));
            if (we[eg]) check("ram_wdata", 64'(ram_data_in), 64'(wdata[eg*DW +: DW]));
        end else begin
            check("idle_we", 64'(ram_write_enable), 64'(0));
            check("idle_be", 64'(ram_byte_enablers), 64'(0));
        end
        ex = pv ? (64'(1) << pidx) : 64'(0);
        check("rvalid", 64'(rvalid), ex);
        if (pv) check("rdata", 64'(rdata), 64'(pdata));
        @(posedge clock);
        if (reset) begin
            pv = 0;
            if (eg >= 0) begin
                a = int'(addr[eg*AW+2 +: 16]);
                if (we[eg]) begin
                    w = sh_rd(a);
                    for (int b = 0; b < 4; b++)
                        if (be[eg*4+b]) w[b*8 +: 8] = wdata[eg*DW + b*8 +: 8];
                    sh[a] = w; shv[a] = 1;
                end else begin
                    pv = 1; pidx = eg; pdata = sh_rd(a);
                end
            end
            if (m_lock && req[m_owner]) begin
                m_cnt++;
                if (!lock[m_owner] || m_cnt >= ML) begin
                    m_lock = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
                end
            end else begin
                if (m_lock) begin
                    m_lock = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
                end
                if (eg >= 0) begin
                    m_ptr = (eg + 1) % N;
                    if (lock[eg] && ML > 1) begin
                        m_lock = 1; m_owner = eg; m_cnt = 1;
                    end
                end
            end
        end
        @(negedge clock);
    endtask

    logic [3:0] tail_seq [4];

    initial begin
        chks = 0; errs = 0; m_ptr = 0; m_cnt = 0; m_owner = 0; m_lock = 0;
        pv = 0; pidx = 0; pdata = '0; eg = -1; last_g = -1;
        tail_seq = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        reset = 1'b0; req = '0; lock = '0; we = '0; be = '1; wdata = '0;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(32'h100 + 4*i);
        @(negedge clock);

        // Reset holds off all grants even with every requester asking
        req = 4'b1111;
        expect_gnt("rst_gnt", 4'b0000);
        check("rst_we", 64'(ram_write_enable), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        cyc(); cyc();

        // Round-robin, all reads
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expect_gnt("rr_seq", 4'(1 << (k % 4)));
            cyc();
        end
        req = '0; cyc();

        // Full then partial write by requester 2, each read back
        req = 4'b0100; we = 4'b0100;
        addr[2*AW +: AW] = 18'h00010; wdata[2*DW +: DW] = 32'hA1B2C3D4; be[8 +: 4] = 4'b1111;
        cyc();
        we = '0; cyc();
        req = '0;
        #1;
        check("wr_rd_rvalid", 64'(rvalid), 64'(4'b0100));
        check("wr_rd_rdata", 64'(rdata), 64'(32'hA1B2C3D4));
        cyc();
        req = 4'b0100; we = 4'b0100; wdata[2*DW +: DW] = 32'h0000FFFF; be[8 +: 4] = 4'b0011;
        cyc();
        we = '0; cyc();
        req = '0;
        #1;
        check("part_rdata", 64'(rdata), 64'(32'hA1B2FFFF));
        cyc();

        // Lock burst by requester 1 against full contention
        be = '1;
        req = 4'b0001; cyc();
        req = 4'b1111; lock = 4'b0010;
        for (int k = 0; k < 12; k++) begin
            expect_gnt("lock_seq", (k < 8) ? 4'b0010 : tail_seq[k-8]);
            cyc();
        end
        req = '0; lock = '0; cyc();

        // Pointer wrap, then owner 0 drops request mid-lock
        req = 4'b0100; cyc();
        req = 4'b1001; lock = 4'b0001;
        expect_gnt("wrap3", 4'b1000); cyc();
        expect_gnt("wrap0", 4'b0001); cyc();
        expect_gnt("lock0", 4'b0001); cyc();
        req = 4'b1010; lock = '0;
        expect_gnt("drop_rr", 4'b0010); cyc();
        req = '0; cyc();

        // Reset asserted in the cycle after a read grant
        req = 4'b0100; cyc();
        req = '0; reset = 1'b0;
        #1;
        check("rst_mid_rvalid", 64'(rvalid), 64'(0));
        cyc();
        reset = 1'b1;
        cyc(); cyc();

        // Randomised traffic with the hold-until-granted protocol
        last_g = -1;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || last_g == i) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[i] = 1'b1;
                        we[i]  = 1'($urandom_range(0, 1));
                        addr[i*AW +: AW]  = AW'(32'h400 + $urandom_range(0, 255));
                        wdata[i*DW +: DW] = $urandom;
                        be[i*4 +: 4]      = 4'($urandom_range(0, 15));
                    end else begin
                        req[i] = 1'b0;
                    end
                end
                lock[i] = ($urandom_range(0, 2) == 0);
            end
            cyc();
            last_g = eg;
        end

        $display("Simulation finished: %0d checks, %0d errors", chks, errs);
        $finish;
    end

endmodule
